// File: rtl/dsp_simd_scheduler.sv
// Round-robin scheduler sharing a two-lane SIMD DSP among NUM_REQ requesters.
// Optional perf counters are built when DSP_SIMD_SCHED_PERF_EN is defined.
module dsp_simd_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DSP_LATENCY = 1
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic [NUM_REQ-1:0]    req_valid_i,
  output logic [NUM_REQ-1:0]    req_ready_o,
  input  logic [NUM_REQ*10-1:0] req_a_i,
  input  logic [NUM_REQ*9-1:0]  req_b_i,
  output logic [NUM_REQ-1:0]    rsp_valid_o,
  input  logic [NUM_REQ-1:0]    rsp_ready_i,
  output logic [NUM_REQ*19-1:0] rsp_z_o,
  output logic [9:0]            lane0_a_o,
  output logic [9:0]            lane1_a_o,
  output logic [8:0]            lane0_b_o,
  output logic [8:0]            lane1_b_o,
  input  logic [18:0]           lane0_z_i,
  input  logic [18:0]           lane1_z_i
`ifdef DSP_SIMD_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_grants_o,
  output logic [31:0]           perf_stalls_o
`endif
);

  localparam int IDW = $clog2(NUM_REQ);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never depends on ready, and a response is held until accepted.
  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] eligible;
  logic [IDW-1:0]     ptr;
  logic [IDW-1:0]     ptr_nxt;
  logic [IDW-1:0]     g0_id;
  logic [IDW-1:0]     g1_id;
  logic [IDW-1:0]     last_id;
  logic               g0_vld;
  logic               g1_vld;

  assign eligible = reset_n_i ? (req_valid_i & ~busy) : '0;

  always_comb begin
    int idx;
    idx         = 0;
    g0_vld      = 1'b0;
    g1_vld      = 1'b0;
    g0_id       = '0;
    g1_id       = '0;
    req_ready_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (eligible[idx]) begin
        if (!g0_vld) begin
          g0_vld = 1'b1;
          g0_id  = idx[IDW-1:0];
        end else if (!g1_vld) begin
          g1_vld = 1'b1;
          g1_id  = idx[IDW-1:0];
        end
      end
    end
    if (g0_vld) req_ready_o[g0_id] = 1'b1;
    if (g1_vld) req_ready_o[g1_id] = 1'b1;
  end

  assign last_id = g1_vld ? g1_id : g0_id;
  assign ptr_nxt = (last_id == IDW'(NUM_REQ - 1)) ? '0 : last_id + 1'b1;

  assign lane0_a_o = g0_vld ? req_a_i[10*int'(g0_id) +: 10] : '0;
  assign lane0_b_o = g0_vld ? req_b_i[9*int'(g0_id) +: 9]   : '0;
  assign lane1_a_o = g1_vld ? req_a_i[10*int'(g1_id) +: 10] : '0;
  assign lane1_b_o = g1_vld ? req_b_i[9*int'(g1_id) +: 9]   : '0;

  // Per-lane {valid, id} delay line matching the DSP latency.
  logic [DSP_LATENCY-1:0] l0_vld;
  logic [DSP_LATENCY-1:0] l1_vld;
  logic [IDW-1:0]         l0_id [DSP_LATENCY];
  logic [IDW-1:0]         l1_id [DSP_LATENCY];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      l0_vld <= '0;
      l1_vld <= '0;
      for (int s = 0; s < DSP_LATENCY; s++) begin
        l0_id[s] <= '0;
        l1_id[s] <= '0;
      end
    end else begin
      l0_vld[0] <= g0_vld;
      l1_vld[0] <= g1_vld;
      l0_id[0]  <= g0_id;
      l1_id[0]  <= g1_id;
      for (int s = 1; s < DSP_LATENCY; s++) begin
        l0_vld[s] <= l0_vld[s-1];
        l1_vld[s] <= l1_vld[s-1];
        l0_id[s]  <= l0_id[s-1];
        l1_id[s]  <= l1_id[s-1];
      end
    end
  end

  // A requester has at most one operation outstanding, so a lane exit never
  // collides with a pending response handshake for the same id.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      busy        <= '0;
      ptr         <= '0;
      rsp_valid_o <= '0;
      rsp_z_o     <= '0;
    end else begin
      if (g0_vld || g1_vld) ptr <= ptr_nxt;
      busy        <= (busy | req_ready_o) & ~(rsp_valid_o & rsp_ready_i);
      rsp_valid_o <= rsp_valid_o & ~rsp_ready_i;
      if (l0_vld[DSP_LATENCY-1]) begin
        rsp_valid_o[l0_id[DSP_LATENCY-1]]            <= 1'b1;
        rsp_z_o[19*int'(l0_id[DSP_LATENCY-1]) +: 19] <= lane0_z_i;
      end
      if (l1_vld[DSP_LATENCY-1]) begin
        rsp_valid_o[l1_id[DSP_LATENCY-1]]            <= 1'b1;
        rsp_z_o[19*int'(l1_id[DSP_LATENCY-1]) +: 19] <= lane1_z_i;
      end
    end
  end

`ifdef DSP_SIMD_SCHED_PERF_EN
  logic [1:0]  n_grant;
  logic        stall;
  logic [32:0] grants_sum;

  assign n_grant    = {1'b0, g0_vld} + {1'b0, g1_vld};
  assign stall      = |(eligible & ~req_ready_o);
  assign grants_sum = {1'b0, perf_grants_o} + 33'(n_grant);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_grants_o <= '0;
      perf_stalls_o <= '0;
    end else begin
      perf_grants_o <= grants_sum[32] ? '1 : grants_sum[31:0];
      if (stall && (perf_stalls_o != '1)) perf_stalls_o <= perf_stalls_o + 1'b1;
    end
  end
`endif

endmodule

// File: doc/dsp_simd_scheduler.md
DSP_SIMD_SCHEDULER -- requirements
Module: dsp_simd_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter DSP_LATENCY, default 1, meaning cycles from lane operands to lane result (1..4).
REQ-003 The block SHALL have port clock_i  input  1  single clock; all logic on rising edge.
REQ-004 The block SHALL have port reset_n_i  input  1  reset; asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid_i  input  NUM_REQ  per-requester operand valid.
REQ-006 The block SHALL have port req_ready_o  output  NUM_REQ  per-requester grant; handshake when valid and ready are both high.
REQ-007 The block SHALL have port req_a_i  input  NUM_REQ*10  unsigned a operands; requester k at bits [10k+9:10k].
REQ-008 The block SHALL have port req_b_i  input  NUM_REQ*9  unsigned b operands; requester k at bits [9k+8:9k].
REQ-009 The block SHALL have port rsp_valid_o  output  NUM_REQ  per-requester result valid.
REQ-010 The block SHALL have port rsp_ready_i  input  NUM_REQ  per-requester result accept.
REQ-011 The block SHALL have port rsp_z_o  output  NUM_REQ*19  results; requester k at bits [19k+18:19k].
REQ-012 The block SHALL have ports lane0_a_o / lane1_a_o  output  10  operand a to SIMD DSP lane 0 / lane 1.
REQ-013 The block SHALL have ports lane0_b_o / lane1_b_o  output  9  operand b to SIMD DSP lane 0 / lane 1.
REQ-014 The block SHALL have ports lane0_z_i / lane1_z_i  input  19  unsigned product from lane 0 / lane 1, DSP_LATENCY cycles after operands.

Function
REQ-015 Requester k SHALL be eligible when req_valid_i[k]=1 and busy[k]=0; busy[k] is set on its request handshake and cleared on its response handshake.
REQ-016 Each cycle the block SHALL grant at most two eligible requesters, searched round-robin starting at pointer ptr; the first found goes to lane 0, the second to lane 1.
REQ-017 req_ready_o SHALL be combinational from req_valid_i, busy and ptr; a non-eligible requester SHALL see req_ready_o=0.
REQ-018 After a cycle with at least one grant, ptr SHALL become (index of last granted requester + 1) mod NUM_REQ; with no grant ptr SHALL hold.
REQ-019 Granted operands SHALL drive the lane outputs combinationally in the grant cycle; an unused lane SHALL drive zero operands.
REQ-020 The block SHALL track each lane with a DSP_LATENCY-deep {valid, requester-id} shift register; on exit it SHALL capture laneN_z_i into rsp_z_o of that id and set rsp_valid_o[id].
REQ-021 Request-to-response latency SHALL be exactly DSP_LATENCY cycles (rsp_valid_o high DSP_LATENCY edges after the handshake edge).
REQ-022 rsp_valid_o[k] and rsp_z_o[k] SHALL hold until rsp_ready_i[k]=1; handshake clears rsp_valid_o[k] and busy[k] on that edge.
REQ-023 A requester whose response handshakes in cycle t SHALL be eligible from cycle t+1, not in cycle t.
REQ-024 Round-robin pointer wrap SHALL be modulo NUM_REQ; no requester SHALL wait more than ceil((NUM_REQ-1)/2) grant cycles once eligible.
REQ-025 rsp_ready_i[k] with rsp_valid_o[k]=0 SHALL have no effect.

Reset
REQ-026 On reset_n_i low, asynchronously: rsp_valid_o=0, rsp_z_o=0, busy=0, ptr=0, lane pipelines cleared; req_ready_o=0 while reset is low.
REQ-027 Reset mid-operation SHALL discard all in-flight and pending results; no rsp_valid_o SHALL assert for pre-reset requests.

Configuration
REQ-028 With macro DSP_SIMD_SCHED_PERF_EN defined, ports perf_grants_o (output 32, total request handshakes) and perf_stalls_o (output 32, cycles with at least one eligible requester not granted) SHALL exist, reset to 0, saturate at 2^32-1.
REQ-029 Without DSP_SIMD_SCHED_PERF_EN the counters and ports SHALL be absent; all other behaviour identical.

Verification
REQ-030 NUM_REQ=4, DSP_LATENCY=1, req 0 only, a=1023 b=511 -> lane0 a=1023 b=511, lane1 zero, rsp_z_o[0]=522753 one cycle later.
REQ-031 All four valid, rsp_ready_i=1111, ptr=0 -> cycle 0 grants 0 (lane0),1 (lane1); cycle 1 grants 2,3; ptr returns to 0.
REQ-032 Req 2 result held with rsp_ready_i[2]=0 for 5 cycles -> rsp_valid_o[2] steady, rsp_z_o[2] unchanged, req_ready_o[2]=0 throughout.
REQ-033 DSP_LATENCY=3, reqs 1 and 3 granted same cycle with 5*7 and 9*8 -> rsp_z_o[1]=35, rsp_z_o[3]=72 exactly 3 cycles later.
REQ-034 reset_n_i pulsed low one cycle after grants to 0 and 1 -> no rsp_valid_o asserts; next grant search starts at ptr=0.
REQ-035 With DSP_SIMD_SCHED_PERF_EN, three eligible requesters for 2 cycles -> perf_grants_o=3 (2+1), perf_stalls_o=1.
